// File: rtl/peridot_servo_sweep.sv
// Servo slew sequencer: ramps per-channel positions toward targets each update tick and writes them out.
// Optional IRQ output and control IRQEN bit are enabled by defining PERIDOT_SERVO_SWEEP_IRQ_EN.
module peridot_servo_sweep #(
  parameter int CHANNEL   = 30,
  parameter int CLOCKFREQ = 25000000,
  parameter int UPDATE_HZ = 50
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [4:0]  avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
`ifdef PERIDOT_SERVO_SWEEP_IRQ_EN
  ,
  output logic        ins_irq
`endif
);

  localparam logic [23:0] DIV_TERM = 24'(CLOCKFREQ / UPDATE_HZ - 1);
  localparam logic [4:0]  CH_LAST  = 5'(CHANNEL - 1);

  typedef enum logic [1:0] {IDLE, ENA, CALC, WR} state_e;

  state_e      state_q, state_d;
  logic [4:0]  ch_q, ch_d;
  logic [23:0] div_q;
  logic        tick;
  logic        run_q, ovr_q, ena_q, ena_d;
  logic [7:0]  step_q;
  logic [7:0]  tgt_q [32];
  logic [7:0]  cur_q [32];
  logic        avm_write_q, avm_write_d;
  logic [4:0]  avm_address_q, avm_address_d;
  logic [7:0]  avm_data_q, avm_data_d;
  logic [31:0] avs_readdata_q;
  logic        cur_we, scan_done, adv;
  logic [7:0]  tgt_sel, cur_sel, next_pos, rd_byte;
  logic [8:0]  diff;
  logic [4:0]  ch_idx;
  logic        addr_ch_ok, wr_ctrl, wr_step, wr_tgt, irqen_bit, all_eq;
  logic        unused_bits;

`ifdef PERIDOT_SERVO_SWEEP_IRQ_EN
  logic irqen_q, irq_q;
  assign irqen_bit = irqen_q;
  assign ins_irq   = irq_q;
`else
  assign irqen_bit = 1'b0;
`endif

  assign unused_bits   = ^{avs_read, avs_writedata[31:8], avs_writedata[3]};
  assign tick          = (div_q == DIV_TERM);
  assign ch_idx        = avs_address - 5'd2;
  assign addr_ch_ok    = (avs_address >= 5'd2) && (ch_idx <= CH_LAST);
  assign wr_ctrl       = avs_write && (avs_address == 5'd0);
  assign wr_step       = avs_write && (avs_address == 5'd1);
  assign wr_tgt        = avs_write && addr_ch_ok;
  assign avs_readdata  = avs_readdata_q;
  assign avm_write     = avm_write_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = {24'b0, avm_data_q};

  // Slew computation for the channel currently selected by the scan
  always_comb begin
    tgt_sel = tgt_q[ch_q];
    cur_sel = cur_q[ch_q];
    diff    = (tgt_sel >= cur_sel) ? ({1'b0, tgt_sel} - {1'b0, cur_sel})
                                   : ({1'b0, cur_sel} - {1'b0, tgt_sel});
    if (step_q == 8'd0 || diff <= {1'b0, step_q})
      next_pos = tgt_sel;
    else if (tgt_sel > cur_sel)
      next_pos = cur_sel + step_q;
    else
      next_pos = cur_sel - step_q;
    all_eq = 1'b1;
    for (int i = 0; i < CHANNEL; i++)
      if (cur_q[i] != tgt_q[i]) all_eq = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    ena_d         = ena_q;
    avm_write_d   = avm_write_q;
    avm_address_d = avm_address_q;
    avm_data_d    = avm_data_q;
    cur_we        = 1'b0;
    scan_done     = 1'b0;
    adv           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_q != ena_q) begin
          state_d       = ENA;
          avm_write_d   = 1'b1;
          avm_address_d = 5'd0;
          avm_data_d    = {7'b0, run_q};
        end else if (tick && run_q) begin
          ch_d    = 5'd0;
          state_d = CALC;
        end
      end
      ENA: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          ena_d       = avm_data_q[0];
          state_d     = IDLE;
        end
      end
      CALC: begin
        if (next_pos != cur_sel) begin
          cur_we        = 1'b1;
          avm_write_d   = 1'b1;
          avm_address_d = ch_q + 5'd2;
          avm_data_d    = next_pos;
          state_d       = WR;
        end else begin
          adv = 1'b1;
        end
      end
      WR: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          adv         = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A cleared RUN aborts the scan at the next channel boundary
    if (adv) begin
      if (ch_q == CH_LAST || !run_q) begin
        state_d   = IDLE;
        scan_done = (ch_q == CH_LAST);
      end else begin
        ch_d    = ch_q + 5'd1;
        state_d = CALC;
      end
    end
  end

  always_comb begin
    rd_byte = 8'd0;
    case (avs_address)
      5'd0:    rd_byte = {4'b0, irqen_bit, ovr_q, (state_q != IDLE), run_q};
      5'd1:    rd_byte = step_q;
      default: if (addr_ch_ok) rd_byte = cur_q[ch_idx];
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state_q        <= IDLE;
      ch_q           <= 5'd0;
      div_q          <= 24'd0;
      run_q          <= 1'b0;
      ovr_q          <= 1'b0;
      ena_q          <= 1'b0;
      step_q         <= 8'd0;
      avm_write_q    <= 1'b0;
      avm_address_q  <= 5'd0;
      avm_data_q     <= 8'd0;
      avs_readdata_q <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        tgt_q[i] <= 8'd128;
        cur_q[i] <= 8'd128;
      end
`ifdef PERIDOT_SERVO_SWEEP_IRQ_EN
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
`endif
    end else begin
      div_q          <= tick ? 24'd0 : div_q + 24'd1;
      state_q        <= state_d;
      ch_q           <= ch_d;
      ena_q          <= ena_d;
      avm_write_q    <= avm_write_d;
      avm_address_q  <= avm_address_d;
      avm_data_q     <= avm_data_d;
      avs_readdata_q <= {24'b0, rd_byte};
      if (wr_ctrl) run_q <= avs_writedata[0];
      if (wr_step) step_q <= avs_writedata[7:0];
      if (tick && state_q != IDLE)
        ovr_q <= 1'b1;
      else if (wr_ctrl && avs_writedata[2])
        ovr_q <= 1'b0;
      if (wr_tgt) tgt_q[ch_idx] <= avs_writedata[7:0];
      if (cur_we) cur_q[ch_q] <= next_pos;
`ifdef PERIDOT_SERVO_SWEEP_IRQ_EN
      if (wr_ctrl) irqen_q <= avs_writedata[3];
      if (wr_tgt)
        irq_q <= 1'b0;
      else if (scan_done)
        irq_q <= irqen_q & run_q & all_eq;
`endif
    end
  end

endmodule
